// File: rtl/imgproc_frame_ctrl.sv
// imgproc_frame_ctrl: frame sequencer for the camera pipeline.
// Tracks FVAL/DVAL, drives pixel counters, mode latch, drain window.
module imgproc_frame_ctrl #(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int DRAIN_CYC = 642
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iFVAL,
  input  logic        iDVAL,
  input  logic        iSW,
  output logic [15:0] oX_Cont,
  output logic [15:0] oY_Cont,
  output logic        oMODE,
  output logic        oSOF,
  output logic        oEOF,
  output logic        oBUSY,
  output logic [15:0] oFRAME_CNT,
  output logic        oERR
);

  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [15:0] X_LAST = 16'(WIDTH - 1);
  localparam logic [15:0] Y_LAST = 16'(HEIGHT - 1);
  localparam logic [DW-1:0] D_LOAD = DW'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_ACT   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          fval_q, fval_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [15:0]   x_q, x_d;
  logic [15:0]   y_q, y_d;
  logic          mode_q, mode_d;
  logic          sof_q, sof_d;
  logic          eof_q, eof_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          err_q, err_d;

  logic rise;
  logic last;

  assign rise = iFVAL & ~fval_q;
  assign last = (x_q == X_LAST) && (y_q == Y_LAST);

  // Next-state: frame sequencing, pixel counters, drain timer, status.
  always_comb begin
    state_d = state_q;
    fval_d  = iFVAL;
    drain_d = drain_q;
    x_d     = x_q;
    y_d     = y_q;
    mode_d  = mode_q;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      S_WAIT: begin
        if (rise) begin
          state_d = S_ACT;
          x_d     = 16'd0;
          y_d     = 16'd0;
          mode_d  = iSW;
          sof_d   = 1'b1;
        end
      end
      S_ACT: begin
        if (iDVAL && last) begin
          // Last pixel wins over a coincident FVAL drop.
          state_d = S_DRAIN;
          drain_d = D_LOAD;
          eof_d   = 1'b1;
          cnt_d   = cnt_q + 16'd1;
          x_d     = 16'd0;
          y_d     = 16'd0;
        end else if (!iFVAL) begin
          state_d = S_DRAIN;
          drain_d = D_LOAD;
          err_d   = 1'b1;
        end else if (iDVAL) begin
          if (x_q != X_LAST) begin
            x_d = x_q + 16'd1;
          end else begin
            x_d = 16'd0;
            y_d = y_q + 16'd1;
          end
        end
      end
      S_DRAIN: begin
        // A frame starting here cannot be processed; it is dropped.
        if (rise) err_d = 1'b1;
        if (drain_q == '0) begin
          state_d = S_WAIT;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  // State and registered outputs, cleared asynchronously on reset.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= S_WAIT;
      fval_q  <= 1'b0;
      drain_q <= '0;
      x_q     <= 16'd0;
      y_q     <= 16'd0;
      mode_q  <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      cnt_q   <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fval_q  <= fval_d;
      drain_q <= drain_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mode_q  <= mode_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign oX_Cont    = x_q;
  assign oY_Cont    = y_q;
  assign oMODE      = mode_q;
  assign oSOF       = sof_q;
  assign oEOF       = eof_q;
  assign oBUSY      = (state_q != S_WAIT);
  assign oFRAME_CNT = cnt_q;
  assign oERR       = err_q;

endmodule

// File: tb/tb_imgproc_frame_ctrl.sv
// tb_imgproc_frame_ctrl: randomized frames, event scoreboard.
// Stimulus predicts events; a negedge monitor matches them.
module tb_imgproc_frame_ctrl;

  localparam int W = 4;
  localparam int H = 3;
  localparam int D = 6;

  localparam int K_SOF  = 0;
  localparam int K_PIX  = 1;
  localparam int K_EOF  = 2;
  localparam int K_FALL = 3;

  typedef struct {
    int kind;
    int cyc;
    int x;
    int y;
    int mode;
    int cnt;
    int err;
  } ev_t;

  logic        clk;
  logic        iRST;
  logic        iFVAL;
  logic        iDVAL;
  logic        iSW;
  logic [15:0] oX_Cont;
  logic [15:0] oY_Cont;
  logic        oMODE;
  logic        oSOF;
  logic        oEOF;
  logic        oBUSY;
  logic [15:0] oFRAME_CNT;
  logic        oERR;

  imgproc_frame_ctrl #(
    .WIDTH(W),
    .HEIGHT(H),
    .DRAIN_CYC(D)
  ) dut (
    .iCLK(clk),
    .iRST(iRST),
    .iFVAL(iFVAL),
    .iDVAL(iDVAL),
    .iSW(iSW),
    .oX_Cont(oX_Cont),
    .oY_Cont(oY_Cont),
    .oMODE(oMODE),
    .oSOF(oSOF),
    .oEOF(oEOF),
    .oBUSY(oBUSY),
    .oFRAME_CNT(oFRAME_CNT),
    .oERR(oERR)
  );

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  ev_t q[$];

  int  cnt = 0;
  int  err = 0;
  int  cur_mode = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_SOF:   return "sof";
      K_PIX:   return "pix";
      K_EOF:   return "eof";
      default: return "busy_fall";
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_x"}, int'(oX_Cont), 0);
    chk({tag, "_y"}, int'(oY_Cont), 0);
    chk({tag, "_mode"}, int'(oMODE), 0);
    chk({tag, "_sof"}, int'(oSOF), 0);
    chk({tag, "_eof"}, int'(oEOF), 0);
    chk({tag, "_busy"}, int'(oBUSY), 0);
    chk({tag, "_cnt"}, int'(oFRAME_CNT), 0);
    chk({tag, "_err"}, int'(oERR), 0);
  endtask

  task automatic push(input int k, input int c, input int x, input int y);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.x    = x;
    e.y    = y;
    e.mode = cur_mode;
    e.cnt  = cnt;
    e.err  = err;
    q.push_back(e);
  endtask

  task automatic observe(input int k);
    ev_t e;
    bit  ok;
    int  gx;
    int  gy;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s at cycle %0d, required no event",
               kname(k), cyc);
      return;
    end
    e  = q.pop_front();
    gx = int'(oX_Cont);
    gy = int'(oY_Cont);
    ok = (e.kind == k) && (e.cyc == cyc) &&
         (int'(oMODE) == e.mode) && (int'(oFRAME_CNT) == e.cnt) &&
         (int'(oERR) == e.err);
    if (k == K_PIX) ok = ok && (gx == e.x) && (gy == e.y);
    if (!ok) begin
      errors++;
      $display({"FAIL %s: got cyc=%0d x=%0d y=%0d mode=%0d cnt=%0d",
                " err=%0d; required %s cyc=%0d x=%0d y=%0d mode=%0d",
                " cnt=%0d err=%0d"},
               kname(k), cyc, gx, gy, oMODE, oFRAME_CNT, oERR,
               kname(e.kind), e.cyc, e.x, e.y, e.mode, e.cnt, e.err);
    end
  endtask

  // Monitor: turns DUT output activity into events and scores them.
  initial begin
    bit busy_prev;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (iRST) begin
        busy_prev = 1'b0;
      end else begin
        if (oSOF) observe(K_SOF);
        if (iDVAL && oBUSY) observe(K_PIX);
        if (oEOF) observe(K_EOF);
        if (busy_prev && !oBUSY) observe(K_FALL);
        busy_prev = oBUSY;
      end
    end
  end

  // One frame attempt. npix pixels are offered (W*H is a full frame).
  // rise_off > 0 re-raises FVAL that many cycles into DRAIN.
  task automatic run_frame(input bit mode, input int npix, input bit gap,
                           input bit tog, input bit fall_last,
                           input int rise_off, input bit rst_mid);
    int i;
    int e;
    step();
    iFVAL = 1'b1;
    iSW   = mode;
    iDVAL = 1'b1;
    cur_mode = int'(mode);
    push(K_SOF, cyc + 1, 0, 0);
    i = 0;
    while (i < npix) begin
      step();
      iDVAL = gap ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tog && (cyc % 3 == 0)) iSW = ~iSW;
      if (iDVAL) begin
        push(K_PIX, cyc, i % W, i / W);
        i++;
        if (i == W * H && fall_last) iFVAL = 1'b0;
      end
    end
    step();
    iDVAL = 1'b0;
    if (rst_mid) begin
      iRST  = 1'b1;
      iFVAL = 1'b0;
      #1;
      chk_zero("rst_mid");
      cnt = 0;
      err = 0;
      cur_mode = 0;
      step();
      iRST = 1'b0;
      step();
      step();
      return;
    end
    iFVAL = 1'b0;
    if (npix == W * H) begin
      cnt = (cnt + 1) & 16'hFFFF;
      e = cyc;
      push(K_EOF, e, 0, 0);
    end else begin
      err = 1;
      e = cyc + 1;
    end
    if (rise_off > 0) err = 1;
    push(K_FALL, e + D, 0, 0);
    while (cyc < e + D + 2) begin
      step();
      if (rise_off > 0 && cyc == e + rise_off) iFVAL = 1'b1;
    end
    iFVAL = 1'b0;
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    iRST  = 1'b1;
    iFVAL = 1'b0;
    iDVAL = 1'b0;
    iSW   = 1'b0;
    #2;
    chk_zero("reset");
    step();
    step();
    iRST = 1'b0;
    step();

    run_frame(1'b0, W * H, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    run_frame(1'b0, W * H, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    run_frame(1'b1, W * H, 1'b0, 1'b1, 1'b0, -1, 1'b0);
    run_frame(1'b0, W * H, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    run_frame(1'b0, 5, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    run_frame(1'b0, W * H, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    run_frame(1'b1, W * H, 1'b0, 1'b0, 1'b0, 2, 1'b0);
    run_frame(1'b0, W * H, 1'b1, 1'b0, 1'b1, D - 1, 1'b0);
    run_frame(1'b1, W * H, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    run_frame(1'b0, 7, 1'b0, 1'b0, 1'b0, -1, 1'b1);
    run_frame(1'b1, W * H, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    for (int r = 0; r < 4; r++) begin
      run_frame(1'($urandom_range(0, 1)), W * H,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), -1, 1'b0);
    end

    step();
    chk("events_left", q.size(), 0);
    chk("final_cnt", int'(oFRAME_CNT), cnt);
    chk("final_err", int'(oERR), err);
    chk("final_busy", int'(oBUSY), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imgproc_frame_ctrl.md
# imgproc_frame_ctrl

Frame-level sequencer for the camera image-processing pipeline (grayscale conversion, three-row line buffer, 3x3 convolution). It tracks the camera's frame/data-valid stream and generates authoritative column/row counters for the datapath. It latches the display-mode switch only at frame start so the output never tears mid-frame. It also holds a busy window while the line buffer drains, and counts completed frames and flags malformed ones.

## Interface
Parameters:
- WIDTH, 640, active pixels per row (2..65535)
- HEIGHT, 480, active rows per frame (2..65535)
- DRAIN_CYC, 642, cycles held in DRAIN after the last pixel (WIDTH+2 covers the line-buffer flush); must be >= 1

Ports:
- iCLK  in  1  pipeline clock; one clock domain
- iRST  in  1  reset, asynchronous, active-high
- iFVAL  in  1  camera frame valid
- iDVAL  in  1  camera pixel valid; one pixel per cycle when high
- iSW  in  1  mode request (0 grayscale, 1 edge detect); sampled only at SOF
- oX_Cont  out  16  column of the pixel accepted this cycle
- oY_Cont  out  16  row of the pixel accepted this cycle
- oMODE  out  1  mode latched for the current frame; drives the convolution select
- oSOF  out  1  one-cycle start-of-frame pulse
- oEOF  out  1  one-cycle end-of-frame pulse
- oBUSY  out  1  high in ACTIVE and DRAIN
- oFRAME_CNT  out  16  completed frames, wraps at 65535->0
- oERR  out  1  sticky malformed-frame flag; cleared only by reset

## Operation
- States: WAIT_SOF, ACTIVE, DRAIN. Reset state is WAIT_SOF.
- fval_d is a registered copy of iFVAL. A rise is iFVAL=1 & fval_d=0.
- WAIT_SOF:
  - iDVAL is ignored.
  - On a rise, the next edge enters ACTIVE, clears X and Y to 0, loads oMODE<=iSW and asserts oSOF for exactly that one cycle.
- ACTIVE, each cycle with iDVAL=1 (an accepted pixel):
  - If X<WIDTH-1: X<=X+1.
  - Otherwise: X<=0 and Y<=Y+1.
  - Accepting pixel (WIDTH-1, HEIGHT-1) enters DRAIN at the next edge, pulses oEOF for that cycle and increments oFRAME_CNT.
  - iDVAL=0 holds the counters.
- Short frame: iFVAL=0 in ACTIVE before the last pixel sets oERR and enters DRAIN. No oEOF pulse, no frame count.
- DRAIN:
  - A down-counter loaded with DRAIN_CYC-1 on entry; DRAIN exits to WAIT_SOF when it reads 0.
  - iDVAL is ignored.
  - A rise during DRAIN sets oERR and that frame is skipped; WAIT_SOF needs a fresh rise.
- oMODE is stable from SOF through the end of DRAIN. iSW toggles mid-frame have no effect.
- Simultaneous events:
  - The last pixel accepted while iFVAL falls is a good frame: oEOF pulses and oERR is unchanged.
  - iFVAL rise in the same cycle as DRAIN's final cycle: skipped and oERR set, because the state is still DRAIN.
- Reset mid-frame: all state and outputs return to reset values immediately, with no EOF and no count.

## Timing
- Reset values:
  - State WAIT_SOF, fval_d=0, drain counter=0.
  - oX_Cont=0, oY_Cont=0, oMODE=0, oSOF=0, oEOF=0, oBUSY=0, oFRAME_CNT=0, oERR=0.
- All outputs are registered. oBUSY is decoded from the state register.
- SOF latency:
  - iFVAL rises at cycle n; fval_d is still 0, so n is the detection cycle.
  - oSOF=1 and oBUSY=1 at n+1.
  - The first pixel accepted is at n+1 or later; iDVAL at cycle n is dropped.
- X/Y are valid in the same cycle as the accepted iDVAL: the pixel accepted at cycle k carries oX_Cont/oY_Cont at k.
- Last pixel accepted at cycle m:
  - oEOF=1 at m+1; oFRAME_CNT updates at m+1.
  - oBUSY falls at m+1+DRAIN_CYC.
- Counter arithmetic is unsigned 16-bit. X never exceeds WIDTH-1 and Y never exceeds HEIGHT-1.

## Test plan
- Nominal frame, WIDTH=4, HEIGHT=3, DRAIN_CYC=6, continuous iDVAL:
  - (X,Y) sequence (0,0)..(3,0),(0,1)..(3,2).
  - oEOF one cycle after (3,2); oFRAME_CNT 0->1; oBUSY low 7 cycles after the last pixel.
- Gapped iDVAL, random 50% duty, same geometry: counters hold on gaps and the same 12 coordinates appear in order.
- Mode latch: iSW=1 at SOF, then toggle iSW every 3 cycles mid-frame -> oMODE=1 for the whole frame; iSW=0 at the next SOF -> oMODE=0.
- Short frame: drop iFVAL after 5 pixels -> oERR=1, no oEOF, oFRAME_CNT unchanged, DRAIN runs 6 cycles, next frame counts normally.
- iFVAL re-rises during DRAIN -> oERR=1, that frame is not started, the following rise after DRAIN starts a frame.
- Assert iRST at pixel (2,1) -> all outputs 0 asynchronously; after release, a full frame completes with oFRAME_CNT=1.
